// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder (seq_chunk_adder).
// Build option ADDER_SUB_EN is handled in the interface and top files.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/done handshake bundle for seq_chunk_adder.
// With ADDER_SUB_EN defined the bundle carries the extra sub request bit.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

`ifdef ADDER_SUB_EN
  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out, overflow);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out, overflow);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out, overflow);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, overflow);
`endif

endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit adder slice, time-multiplexed by seq_chunk_adder.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
  assign s     = full[CHUNK-1:0];
  assign c_out = full[CHUNK];
  // A sum bit is a^b^carry_in, so the carry into the top bit falls out of it.
  assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, carry registered between chunks.
// Define ADDER_SUB_EN to add the sub request (a - b - borrow_in via inverted B and carry).
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_chunk_adder_if.slave bus
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);

  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_out_q, ovf_q;
  logic             accept, last;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic [CHUNK-1:0] ca, cb, cs;
  logic             cc, cm;

`ifdef ADDER_SUB_EN
  assign b_in   = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub ? ~bus.c_in : bus.c_in;
`else
  assign b_in   = bus.b;
  assign cin_in = bus.c_in;
`endif

  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last   = (int'(idx) == N - 1);

  assign ca = a_q[int'(idx)*CHUNK +: CHUNK];
  assign cb = b_q[int'(idx)*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .c_in (carry),
    .s    (cs),
    .c_out(cc),
    .c_msb(cm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = bus.start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands need no reset: they are only read after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= b_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= cin_in;
    end else if (state == RUN) begin
      sum_q[int'(idx)*CHUNK +: CHUNK] <= cs;
      carry <= cc;
      idx   <= idx + IW'(1);
      if (last) begin
        c_out_q <= cc;
        ovf_q   <= cm ^ cc;
      end
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three builds (CHUNK=4,16,1) driven alike, checked against an arithmetic model.
module tb_seq_chunk_adder;

  localparam int W = 16;
  localparam int NS [3] = '{4, 16, 1};

  logic clk = 1'b0;
  logic rst;
  logic start, c_in, sub;
  logic [W-1:0] a, b;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(W)) i0 ();
  seq_chunk_adder_if #(.WIDTH(W)) i1 ();
  seq_chunk_adder_if #(.WIDTH(W)) i2 ();

  assign i0.start = start; assign i0.a = a; assign i0.b = b; assign i0.c_in = c_in;
  assign i1.start = start; assign i1.a = a; assign i1.b = b; assign i1.c_in = c_in;
  assign i2.start = start; assign i2.a = a; assign i2.b = b; assign i2.c_in = c_in;
`ifdef ADDER_SUB_EN
  assign i0.sub = sub; assign i1.sub = sub; assign i2.sub = sub;
`endif

  seq_chunk_adder #(.WIDTH(W), .CHUNK(4))  dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(1))  dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(16)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  logic         busy_o [3];
  logic         done_o [3];
  logic [W-1:0] sum_o  [3];
  logic         cout_o [3];
  logic         ovf_o  [3];

  assign busy_o[0] = i0.busy; assign done_o[0] = i0.done; assign sum_o[0] = i0.sum;
  assign cout_o[0] = i0.c_out; assign ovf_o[0] = i0.overflow;
  assign busy_o[1] = i1.busy; assign done_o[1] = i1.done; assign sum_o[1] = i1.sum;
  assign cout_o[1] = i1.c_out; assign ovf_o[1] = i1.overflow;
  assign busy_o[2] = i2.busy; assign done_o[2] = i2.done; assign sum_o[2] = i2.sum;
  assign cout_o[2] = i2.c_out; assign ovf_o[2] = i2.overflow;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result packed as {overflow, c_out, sum}.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    logic         ov;
    yy   = s ? ~y : y;
    cc   = s ? ~ci : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Model: remember the edge each build accepted at; busy/done/result follow from edge arithmetic.
  int            edge_no;
  int            acc      [3];
  logic [W+1:0]  res_now  [3];
  logic [W+1:0]  res_pend [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no = 0;
      for (int j = 0; j < 3; j++) begin
        acc[j]     = -1;
        res_now[j] = '0;
      end
    end else begin
      edge_no++;
      for (int j = 0; j < 3; j++) begin
        if (acc[j] >= 0 && edge_no == acc[j] + NS[j]) res_now[j] = res_pend[j];
        if (start && !(acc[j] >= 0 && edge_no - 1 >= acc[j] && edge_no - 1 < acc[j] + NS[j])) begin
          acc[j]      = edge_no;
          res_pend[j] = ref_calc(a, b, c_in, sub);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++) begin
        logic eb, ed;
        eb = acc[j] >= 0 && edge_no >= acc[j] && edge_no < acc[j] + NS[j];
        ed = acc[j] >= 0 && edge_no == acc[j] + NS[j];
        check($sformatf("busy[%0d]", j), busy_o[j], eb);
        check($sformatf("done[%0d]", j), done_o[j], ed);
        if (!eb) begin
          check($sformatf("sum[%0d]", j), sum_o[j], res_now[j][W-1:0]);
          check($sformatf("c_out[%0d]", j), cout_o[j], res_now[j][W]);
          check($sformatf("overflow[%0d]", j), ovf_o[j], res_now[j][W+1]);
        end
      end
    end
  end

  task automatic wait_done0(output int n);
    n = 0;
    while (!done_o[0] && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("done0_seen", done_o[0], 1'b1);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (busy_o[1] && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    check("chunk1_finished", busy_o[1], 1'b0);
  endtask

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                    input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb_v; c_in = tc; sub = ts; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    wait_done0(n);
    check("latency", n, 4);
    check("lit_sum", sum_o[0], es);
    check("lit_c_out", cout_o[0], ec);
    check("lit_overflow", ovf_o[0], eo);
    wait_idle1();
    check("lit_sum_chunk1", sum_o[1], es);
    check("lit_c_out_chunk1", cout_o[1], ec);
    check("lit_sum_chunk16", sum_o[2], es);
    check("lit_c_out_chunk16", cout_o[2], ec);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #1;
    check("rst_busy", busy_o[0], 1'b0);
    check("rst_done", done_o[0], 1'b0);
    check("rst_sum", sum_o[0], 16'h0000);
    check("rst_c_out", cout_o[0], 1'b0);
    check("rst_overflow", ovf_o[0], 1'b0);
    #22 rst = 1'b0;
    @(posedge clk); #2;

    op(16'h0000, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'h0004, 16'h0002, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // A second start two cycles into RUN must not disturb the operation in flight.
    a = 16'h0010; b = 16'h0020; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done0(n);
    check("ignored_start_latency", n, 1);
    check("ignored_start_sum", sum_o[0], 16'h0030);

    // Start held through DONE: accepted immediately.
    a = 16'h0100; b = 16'h0200; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    check("b2b_busy", busy_o[0], 1'b1);
    wait_done0(n);
    check("b2b_latency", n, 4);
    check("b2b_sum", sum_o[0], 16'h0300);
    wait_idle1();

    // Reset during the second RUN cycle aborts the operation.
    a = 16'h00AA; b = 16'h0055; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy_o[0], 1'b0);
    check("abort_done", done_o[0], 1'b0);
    check("abort_sum", sum_o[0], 16'h0000);
    check("abort_c_out", cout_o[0], 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef ADDER_SUB_EN
    op(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    op(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`endif

    // Random traffic, including starts while busy and boundary operands.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start = ($urandom % 4) == 0;
      a     = W'($urandom);
      b     = W'($urandom);
      if ($urandom % 4 == 0) a = (($urandom % 2) == 0) ? 16'h7FFF : 16'hFFFF;
      if ($urandom % 4 == 0) b = (($urandom % 2) == 0) ? 16'h8000 : 16'h0001;
      c_in  = 1'($urandom);
`ifdef ADDER_SUB_EN
      sub   = 1'($urandom);
`else
      sub   = 1'b0;
`endif
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
